// File: rtl/if_axi_fetch_pkg.sv
// Shared definitions for the IF-stage AXI fetch master: stall bus, AXI constants, FSM encodings.
package if_axi_fetch_pkg;

    localparam int         STALL_BUS = 5;
    localparam logic       STOP      = 1'b1;
    localparam logic       NOSTOP    = 1'b0;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AR    = 3'd1,
        ST_R     = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/if_axi_fetch.sv
// Instruction-fetch AXI read master: one single-beat read per IF request.
// Latency: instruction valid 3 cycles after request with zero-wait AXI.
// Backpressure: holds the instruction in DONE while stall_i[1]; stallreq_if high while a read is pending.
module if_axi_fetch
    import if_axi_fetch_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'h0,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input  logic                 cpu_clk_50M,
    input  logic                 cpu_rst,
    input  logic [ADDR_W-1:0]    pc_i,
    input  logic                 req_i,
    input  logic [STALL_BUS-1:0] stall_i,
    input  logic                 flush_i,
    output logic [DATA_W-1:0]    inst_o,
    output logic                 inst_valid_o,
    output logic                 inst_err_o,
    output logic                 stallreq_if,
    output logic [3:0]           arid,
    output logic [ADDR_W-1:0]    araddr,
    output logic [7:0]           arlen,
    output logic [2:0]           arsize,
    output logic [1:0]           arburst,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [3:0]           rid,
    input  logic [DATA_W-1:0]    rdata,
    input  logic [1:0]           rresp,
    input  logic                 rlast,
    input  logic                 rvalid,
    output logic                 rready
);

    fetch_state_t state, state_nxt;
    logic         flushed, flushed_nxt;
    logic         load_addr;
    logic         load_inst;
    logic         beat;

    assign arid    = AXI_ID;
    assign arlen   = 8'd0;
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;
    assign beat    = rvalid & rlast;

    // Only one read is ever in flight, so the returned ID carries no information.
    logic unused_ok;
    assign unused_ok = ^{rid, stall_i[STALL_BUS-1:2], stall_i[0]};

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state      <= ST_IDLE;
            flushed    <= 1'b0;
            araddr     <= '0;
            inst_o     <= '0;
            inst_err_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            flushed <= flushed_nxt;
            if (load_addr) begin
                araddr <= pc_i;
            end
            if (load_inst) begin
                inst_o     <= rdata;
                inst_err_o <= (rresp != RESP_OKAY);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        flushed_nxt  = flushed;
        load_addr    = 1'b0;
        load_inst    = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        inst_valid_o = 1'b0;
        stallreq_if  = NOSTOP;
        unique case (state)
            ST_IDLE: begin
                flushed_nxt = 1'b0;
                // Combinational request stall so the PC does not advance past this fetch.
                if (req_i && !flush_i) begin
                    stallreq_if = STOP;
                    load_addr   = 1'b1;
                    state_nxt   = ST_AR;
                end
            end
            ST_AR: begin
                arvalid     = 1'b1;
                stallreq_if = STOP;
                if (flush_i) begin
                    flushed_nxt = 1'b1;
                end
                // The address is never withdrawn; a flushed read still completes and is drained.
                if (arready) begin
                    state_nxt = (flushed || flush_i) ? ST_DRAIN : ST_R;
                end
            end
            ST_R: begin
                rready      = 1'b1;
                stallreq_if = STOP;
                if (beat) begin
                    if (flushed || flush_i) begin
                        flushed_nxt = 1'b0;
                        state_nxt   = ST_IDLE;
                    end else begin
                        load_inst = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end else if (flush_i) begin
                    flushed_nxt = 1'b1;
                end
            end
            ST_DRAIN: begin
                rready      = 1'b1;
                stallreq_if = STOP;
                if (beat) begin
                    flushed_nxt = 1'b0;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_DONE: begin
                inst_valid_o = ~flush_i;
                if (!stall_i[1] || flush_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_if_axi_fetch.sv
// Directed and randomized fetch transactions against a transaction-level expectation of the fetch master.
module tb_if_axi_fetch;

    logic        clk = 1'b0;
    logic        cpu_rst;
    logic [31:0] pc_i;
    logic        req_i;
    logic [4:0]  stall_i;
    logic        flush_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        inst_err_o;
    logic        stallreq_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_axi_fetch #(.AXI_ID(4'h0), .ADDR_W(32), .DATA_W(32)) dut (
        .cpu_clk_50M  (clk),
        .cpu_rst      (cpu_rst),
        .pc_i         (pc_i),
        .req_i        (req_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .inst_err_o   (inst_err_o),
        .stallreq_if  (stallreq_if),
        .arid         (arid),
        .araddr       (araddr),
        .arlen        (arlen),
        .arsize       (arsize),
        .arburst      (arburst),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .rvalid       (rvalid),
        .rready       (rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, inst_valid_o, 0);
        chk({tag, ".stall"}, stallreq_if, 0);
        chk({tag, ".arvalid"}, arvalid, 0);
        chk({tag, ".rready"}, rready, 0);
    endtask

    // fl_mode: 0 none, 1 flush in first AR cycle, 2 flush in R before the beat, 3 flush on the beat.
    // Expected outcome: any flush drops the instruction; otherwise it is presented exactly
    // 3 + ar_wait + r_wait cycles after the request and held for hold+1 cycles.
    task automatic fetch(input logic [31:0] pc, input int ar_wait, input int r_wait,
                         input logic [31:0] data, input logic [1:0] resp,
                         input int fl_mode, input int hold);
        bit dropped;
        dropped = (fl_mode == 1) || (fl_mode == 3) || (fl_mode == 2 && r_wait > 0);
        req_i = 1'b1; pc_i = pc; flush_i = 1'b0; arready = 1'b0; rvalid = 1'b0; stall_i = 5'b0;
        #1;
        chk("req.stall", stallreq_if, 1);
        chk("req.arvalid", arvalid, 0);
        next_cycle();
        req_i = 1'b0; pc_i = ~pc;
        for (int i = 0; i <= ar_wait; i++) begin
            arready = (i == ar_wait);
            flush_i = (fl_mode == 1 && i == 0);
            #1;
            chk("ar.arvalid", arvalid, 1);
            chk("ar.araddr", araddr, pc);
            chk("ar.stall", stallreq_if, 1);
            chk("ar.valid", inst_valid_o, 0);
            chk("ar.fixed", {arid, arlen, arsize, arburst}, {4'h0, 8'h00, 3'b010, 2'b01});
            next_cycle();
        end
        arready = 1'b0; flush_i = 1'b0;
        for (int i = 0; i <= r_wait; i++) begin
            rvalid = (i == r_wait); rlast = 1'b1; rdata = data; rresp = resp;
            rid = 4'($urandom);
            flush_i = (fl_mode == 2 && i == 0 && r_wait > 0) || (fl_mode == 3 && i == r_wait);
            #1;
            chk("r.rready", rready, 1);
            chk("r.stall", stallreq_if, 1);
            chk("r.arvalid", arvalid, 0);
            chk("r.valid", inst_valid_o, 0);
            next_cycle();
        end
        rvalid = 1'b0; flush_i = 1'b0; rdata = 32'hDEAD_BEEF; rresp = 2'b11;
        if (!dropped) begin
            for (int i = 0; i <= hold; i++) begin
                stall_i = (i < hold) ? 5'b00111 : 5'b00101;
                #1;
                chk("done.valid", inst_valid_o, 1);
                chk("done.inst", inst_o, data);
                chk("done.err", inst_err_o, (resp != 2'b00));
                chk("done.stall", stallreq_if, 0);
                chk("done.arvalid", arvalid, 0);
                next_cycle();
            end
            stall_i = 5'b0;
        end
        #1;
        chk_idle("post");
    endtask

    initial begin
        cpu_rst = 1'b1; req_i = 1'b0; pc_i = 32'h0; stall_i = 5'b0; flush_i = 1'b0;
        arready = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        next_cycle();
        next_cycle();
        chk_idle("reset");
        chk("reset.araddr", araddr, 0);
        chk("reset.inst", inst_o, 0);
        chk("reset.err", inst_err_o, 0);
        cpu_rst = 1'b0;
        next_cycle();

        fetch(32'hBFC00000, 0, 0, 32'h24080001, 2'b00, 0, 0);
        fetch(32'h80001000, 0, 0, 32'h3C1D8000, 2'b00, 0, 3);
        fetch(32'h80002000, 5, 1, 32'h27BDFFF0, 2'b00, 0, 0);
        fetch(32'h80003000, 0, 3, 32'h12345678, 2'b00, 2, 0);
        fetch(32'hBFC00380, 0, 0, 32'h0000000C, 2'b00, 0, 0);
        fetch(32'h80004000, 2, 1, 32'hCAFEF00D, 2'b00, 1, 0);
        fetch(32'h80005000, 1, 2, 32'h0BADC0DE, 2'b00, 3, 0);
        fetch(32'h80006000, 0, 1, 32'h8C880000, 2'b10, 0, 1);

        // Flush presented in the same cycle as the request: no fetch may start.
        req_i = 1'b1; flush_i = 1'b1; pc_i = 32'h80007000;
        #1;
        chk("reqflush.stall", stallreq_if, 0);
        next_cycle();
        req_i = 1'b0; flush_i = 1'b0;
        #1;
        chk_idle("reqflush");

        // Reset asserted while the read data phase is pending.
        req_i = 1'b1; pc_i = 32'h80008000; arready = 1'b1;
        next_cycle();
        req_i = 1'b0;
        next_cycle();
        arready = 1'b0; cpu_rst = 1'b1;
        #1;
        chk("rst.rready_before", rready, 1);
        next_cycle();
        chk_idle("rst");
        chk("rst.araddr", araddr, 0);
        chk("rst.inst", inst_o, 0);
        chk("rst.err", inst_err_o, 0);
        cpu_rst = 1'b0;
        next_cycle();
        fetch(32'h80009000, 0, 0, 32'h00000000, 2'b00, 0, 0);

        for (int n = 0; n < 25; n++) begin
            int mode;
            mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            fetch({$urandom_range(0, 32'h3FFFFFFF), 2'b00}, $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom, ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00,
                  mode, $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_axi_fetch.md
Name: if_axi_fetch

Overview:
Instruction-fetch bus master for the 5-stage CPU. It converts each IF-stage fetch request into one single-beat AXI read. It raises stallreq_if toward the stall control unit while the fetch is outstanding. It then holds the returned instruction until the IF/ID register accepts it, as indicated by the stall bus from the stall control unit.

Parameters:
AXI_ID, 4'h0, constant ARID driven on every read.
ADDR_W, 32, address width.
DATA_W, 32, instruction/data width.

Ports:
cpu_clk_50M  in  1  clock; all state updates on rising edge.
cpu_rst  in  1  synchronous, active-high reset.
pc_i  in  ADDR_W  address of the instruction to fetch.
req_i  in  1  IF stage requests a fetch of pc_i.
stall_i  in  5 (STALL_BUS)  stall vector from the stall control unit; bit[1] = IF/ID hold.
flush_i  in  1  exception/redirect; discard the current fetch.
inst_o  out  DATA_W  fetched instruction.
inst_valid_o  out  1  inst_o valid for IF/ID capture.
inst_err_o  out  1  RRESP was not OKAY for inst_o.
stallreq_if  out  1  fetch pending; uses STOP polarity.
arid  out  4  = AXI_ID.
araddr  out  ADDR_W  registered fetch address.
arlen  out  8  constant 0.
arsize  out  3  constant 3'b010.
arburst  out  2  constant 2'b01.
arvalid  out  1  read address valid.
arready  in  1  read address ready.
rid  in  4  ignored; only one read is ever outstanding.
rdata  in  DATA_W  read data.
rresp  in  2  read response.
rlast  in  1  last beat; always 1 with arlen = 0.
rvalid  in  1  read data valid.
rready  out  1  read data ready.

Behaviour:
- States: IDLE, AR, R, DONE, DRAIN. Reset forces IDLE.
- Reset values: araddr = 0, inst_o = 0, inst_err_o = 0, arvalid = 0, rready = 0, inst_valid_o = 0, stallreq_if = 0.
- A reset asserted mid-transaction returns the block to IDLE on the next edge. The AXI interconnect shares cpu_rst, so no drain is performed.
- IDLE:
  - req_i = 1 and flush_i = 0: araddr <= pc_i, go to AR.
  - stallreq_if = req_i & ~flush_i, combinational, so the PC holds in the request cycle.
- AR:
  - arvalid = 1; araddr is held stable until handshake.
  - On arvalid & arready: go to R, or to DRAIN if a flush has been recorded.
  - flush_i in AR sets an internal flushed flag. arvalid is never withdrawn before handshake.
- R:
  - rready = 1.
  - On rvalid & rlast, with flushed = 0 and flush_i = 0: inst_o <= rdata, inst_err_o <= (rresp != 2'b00), go to DONE.
  - If flushed or flush_i is set on that beat: discard the data, go to IDLE.
  - flush_i without a beat: set flushed, remain in R.
- DRAIN:
  - rready = 1.
  - On rvalid & rlast: discard the data, clear flushed, go to IDLE.
- stallreq_if = 1 throughout AR, R and DRAIN.
- DONE:
  - stallreq_if = 0, inst_valid_o = ~flush_i, inst_o held.
  - If stall_i[1] = 0 or flush_i = 1: go to IDLE. IF/ID captures on the same edge.
  - Otherwise hold indefinitely; no new AR is issued.
- Minimum fetch latency with zero-wait AXI: request cycle → AR (1) → R (1) → DONE. inst_valid_o rises 3 cycles after req_i.
- At most one read is outstanding. The flushed flag is cleared in IDLE and on reset.
- Simultaneous flush_i with an arready or rvalid handshake: the handshake completes, and the data is treated as flushed.

Decomposition:
- Shared defines file holds:
  - STALL_BUS and STOP, existing.
  - AXI constants: BURST_INCR 2'b01, SIZE_4B 3'b010, RESP_OKAY 2'b00.
  - The 3-bit state encodings for this block.
- No sub-module: single FSM with a data/address register set.

Test Plan:
1. Zero-wait fetch, pc_i = 32'hBFC00000, arready = 1, rvalid 1 cycle after the AR handshake with rdata = 32'h24080001 → araddr = BFC00000, arlen = 0, arsize = 2; stallreq_if high for cycles 0–2; inst_valid_o = 1 with inst_o = 24080001 in cycle 3.
2. stall_i = 5'b00111 held 3 cycles while in DONE → inst_o/inst_valid_o stable, stallreq_if = 0, arvalid = 0; IDLE one cycle after stall_i[1] drops.
3. arready delayed 5 cycles, pc_i changes to 32'h00000004 meanwhile → arvalid continuously 1, araddr stays at the original PC.
4. flush_i pulse in R before rvalid → rdata discarded, inst_valid_o never asserts; next req_i with pc_i = 32'hBFC00380 issues araddr = BFC00380.
5. flush_i in AR with arready low for 2 cycles → arvalid held until handshake, then DRAIN with rready = 1; the beat is discarded, then IDLE.
6. rresp = 2'b10 on the beat → inst_err_o = 1 in DONE; cpu_rst asserted in R → all outputs 0 and state IDLE on the next edge.
